// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave -- APB3 memory-mapped slave.
//
// Word-addressed memory of DEPTH words of DATA_WIDTH bits. Each transfer
// stretches its access phase by WAIT_STATES cycles (PREADY=0) before it
// completes. Out-of-range or misaligned byte addresses complete with
// PSLVERR=1. Errored writes leave memory untouched, and errored reads
// return 0. Addresses do not alias.
//
// Optional feature (compile-time macro APB_PSTRB_EN):
//   defined   : adds PSTRB[DATA_WIDTH/8-1:0], latched at setup. Writes
//               update only the strobed bytes. PSTRB is ignored on reads.
//   undefined : no PSTRB port. Writes update the full word.
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETn  in   synchronous active-low reset (memory is not cleared)
//   PSELx    in   slave select
//   PENABLE  in   access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [ADDR_WIDTH-1:0] byte address
//   PWDATA   in   [DATA_WIDTH-1:0] write data
//   PSTRB    in   [DATA_WIDTH/8-1:0] byte strobes (APB_PSTRB_EN only)
//   PRDATA   out  [DATA_WIDTH-1:0] read data, registered, 0 unless read done
//   PREADY   out  transfer complete, registered
//   PSLVERR  out  error, registered, only set together with PREADY
// ---------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int LSB = $clog2(BPW);
  localparam int IW  = $clog2(DEPTH);

  // One extra bit so that DEPTH*BPW == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   LIMIT      = (ADDR_WIDTH+1)'(DEPTH * BPW);
  // Masking avoids slicing PADDR[LSB-1:0], which is empty when BPW == 1.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BPW - 1);

  // Elaboration-time parameter checks.
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
  begin : g_bad_dw
    $error("apb_mem_slave: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_mem_slave: DEPTH must be a power of two >= 2");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("apb_mem_slave: WAIT_STATES must be 0..15");
  end
  if (ADDR_WIDTH < LSB + IW) begin : g_bad_aw
    $error("apb_mem_slave: ADDR_WIDTH too small for DEPTH*BPW bytes");
  end

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic [IW-1:0]        idx_q;
  logic                 write_q, err_q;

  logic                 ready_n, slverr_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic                 latch, enter_ready;

  logic                 addr_err;
  logic [IW-1:0]        cur_idx;
  logic                 cur_err, cur_write;
  logic                 mem_we;
  logic [BPW-1:0]       wr_strb;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address check on the live bus. It is only used at the setup edge.
  assign addr_err = ({1'b0, PADDR} >= LIMIT) || ((PADDR & ALIGN_MASK) != '0);

  // With WAIT_STATES=0 the setup edge also enters READY. The transfer
  // attributes are then taken straight from the bus instead of the latches.
  assign cur_idx   = (state == IDLE) ? PADDR[LSB +: IW] : idx_q;
  assign cur_err   = (state == IDLE) ? addr_err         : err_q;
  assign cur_write = (state == IDLE) ? PWRITE           : write_q;

  // ---------------------------------------------------------------------
  // FSM next-state and next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ready_n     = 1'b0;
    slverr_n    = 1'b0;
    rdata_n     = '0;
    latch       = 1'b0;
    enter_ready = 1'b0;

    unique case (state)
      IDLE: begin
        if (PSELx && !PENABLE) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_n     = READY;
            enter_ready = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(WAIT_STATES - 1);
          end
        end
      end

      WAIT: begin
        if (!PSELx) begin
          state_n = IDLE;                 // abort: nothing written
          cnt_n   = '0;
        end else if (PENABLE) begin
          if (cnt == '0) begin
            state_n     = READY;
            enter_ready = 1'b1;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end

      READY: begin
        if (!PSELx || PENABLE) begin
          // Completion (PREADY is 1 throughout READY) or abort.
          state_n = IDLE;
        end else begin
          // PENABLE dropped without PSELx: hold the response.
          ready_n  = PREADY;
          slverr_n = PSLVERR;
          rdata_n  = PRDATA;
        end
      end

      default: state_n = IDLE;
    endcase

    if (enter_ready) begin
      ready_n  = 1'b1;
      slverr_n = cur_err;
      rdata_n  = (!cur_write && !cur_err) ? mem[cur_idx] : '0;
    end
  end

  // ---------------------------------------------------------------------
  // State, latched transfer attributes and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      PREADY  <= ready_n;
      PSLVERR <= slverr_n;
      PRDATA  <= rdata_n;
      if (latch) begin
        idx_q   <= PADDR[LSB +: IW];
        write_q <= PWRITE;
        err_q   <= addr_err;
      end
    end
  end

`ifdef APB_PSTRB_EN
  logic [BPW-1:0] strb_q;
  always_ff @(posedge PCLK) begin
    if (!PRESETn)   strb_q <= '0;
    else if (latch) strb_q <= PSTRB;
  end
  assign wr_strb = strb_q;
`else
  assign wr_strb = '1;
`endif

  // ---------------------------------------------------------------------
  // Memory write on the completing edge. Reset wins over an in-flight write.
  // ---------------------------------------------------------------------
  assign mem_we = PRESETn && (state == READY) && PSELx && PENABLE && write_q && !err_q;

  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int b = 0; b < BPW; b++) begin
        if (wr_strb[b]) mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  bit          fast;          // 0: WAIT_STATES=2 instance, 1: WAIT_STATES=0 instance

  logic        psel_s, psel_f;
  logic [31:0] rdata_s, rdata_f;
  logic        ready_s, ready_f, err_s, err_f;
  logic [31:0] cur_rdata;
  logic        cur_ready, cur_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  assign psel_s    = psel & ~fast;
  assign psel_f    = psel &  fast;
  assign cur_rdata = fast ? rdata_f : rdata_s;
  assign cur_ready = fast ? ready_f : ready_s;
  assign cur_err   = fast ? err_f   : err_s;

  apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel_s), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(rdata_s), .PREADY(ready_s), .PSLVERR(err_s));

  apb_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel_f), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(rdata_f), .PREADY(ready_f), .PSLVERR(err_f));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Setup + access phases. Returns once PREADY=1 is seen (the completing
  // edge is the next one), so a following xfer runs back-to-back.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rd, output logic err,
                      output int waits);
    @(posedge PCLK); #1;
    psel = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PADDR   = addr ^ 32'h4;       // access-phase address must be ignored
    waits   = 0;
    while (cur_ready !== 1'b1 && waits < 20) begin
      waits++;
      @(posedge PCLK); #1;
    end
    rd  = cur_rdata;
    err = cur_err;
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    psel = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_err, input logic [3:0] strb = 4'hF);
    logic [31:0] rd; logic err; int waits;
    xfer(1'b1, addr, data, strb, rd, err, waits);
    chk({tag, "_waits"}, 64'(waits), fast ? 64'd0 : 64'd2);
    chk({tag, "_slverr"}, 64'(err), 64'(exp_err));
    chk({tag, "_prdata"}, 64'(rd), 64'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                    input logic exp_err);
    logic [31:0] d; logic err; int waits;
    xfer(1'b0, addr, 32'h0, 4'hF, d, err, waits);
    chk({tag, "_waits"}, 64'(waits), fast ? 64'd0 : 64'd2);
    chk({tag, "_slverr"}, 64'(err), 64'(exp_err));
    chk({tag, "_prdata"}, 64'(d), 64'(exp_data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d; logic e; int w;
    PRESETn = 1'b0; psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = 4'hF; fast = 1'b0;

    // 1. reset state, then a reset landing on the completing edge of a write
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", 64'(ready_s), 64'd0);
    chk("rst_pslverr", 64'(err_s), 64'd0);
    chk("rst_prdata", 64'(rdata_s), 64'd0);
    chk("rst0_pready", 64'(ready_f), 64'd0);
    PRESETn = 1'b1;
    wr("pre_w10", 32'h10, 32'h1111_1111, 1'b0);
    idle();
    xfer(1'b1, 32'h10, 32'h2222_2222, 4'hF, d, e, w);
    chk("mid_ready", 64'(ready_s), 64'd1);
    PRESETn = 1'b0;
    repeat (2) begin
      @(posedge PCLK); #1;
      chk("midrst_pready", 64'(ready_s), 64'd0);
      chk("midrst_pslverr", 64'(err_s), 64'd0);
      chk("midrst_prdata", 64'(rdata_s), 64'd0);
    end
    PRESETn = 1'b1; psel = 1'b0; PENABLE = 1'b0;
    rd("rst_nowrite", 32'h10, 32'h1111_1111, 1'b0);
    idle();

    // 2. write then back-to-back read of the same word
    wr("w10", 32'h10, 32'hDEAD_BEEF, 1'b0);
    rd("r10", 32'h10, 32'hDEAD_BEEF, 1'b0);
    idle();

    // 3. out of range
    wr("w00", 32'h00, 32'hA5A5_A5A5, 1'b0);
    rd("r80", 32'h80, 32'h0, 1'b1);
    wr("w80", 32'h80, 32'h0000_1234, 1'b1);
    rd("r00", 32'h00, 32'hA5A5_A5A5, 1'b0);
    wr("w7c", 32'h7C, 32'hCAFE_F00D, 1'b0);
    rd("r7c", 32'h7C, 32'hCAFE_F00D, 1'b0);
    rd("r7f", 32'h7F, 32'h0, 1'b1);
    rd("rtop", 32'hFFFF_FFFC, 32'h0, 1'b1);
    idle();

    // 4. misaligned write, then abort during WAIT
    wr("w04", 32'h04, 32'h4444_4444, 1'b0);
    wr("w08", 32'h08, 32'h8888_8888, 1'b0);
    wr("w06", 32'h06, 32'hFFFF_FFFF, 1'b1);
    rd("r04", 32'h04, 32'h4444_4444, 1'b0);
    rd("r08", 32'h08, 32'h8888_8888, 1'b0);
    wr("w0c", 32'h0C, 32'h3333_3333, 1'b0);
    idle();
    @(posedge PCLK); #1;
    psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'h9999_9999;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_wait_pready", 64'(ready_s), 64'd0);
    psel = 1'b0; PENABLE = 1'b0;
    repeat (2) begin
      @(posedge PCLK); #1;
      chk("abort_pready", 64'(ready_s), 64'd0);
      chk("abort_pslverr", 64'(err_s), 64'd0);
    end
    rd("r0c", 32'h0C, 32'h3333_3333, 1'b0);
    idle();

    // 5. zero-wait instance, back-to-back sweep of all words
    fast = 1'b1;
    for (int i = 0; i < 32; i++) wr($sformatf("f_w%0d", i), 32'(i * 4), 32'(i * 3), 1'b0);
    for (int i = 0; i < 32; i++) rd($sformatf("f_r%0d", i), 32'(i * 4), 32'(i * 3), 1'b0);
    rd("f_r80", 32'h80, 32'h0, 1'b1);
    idle();
    fast = 1'b0;

`ifdef APB_PSTRB_EN
    // 6. byte strobes
    wr("s_full", 32'h20, 32'hAABB_CCDD, 1'b0, 4'hF);
    wr("s_0101", 32'h20, 32'h1122_3344, 1'b0, 4'b0101);
    rd("s_r1", 32'h20, 32'hAA22_CC44, 1'b0);
    wr("s_none", 32'h20, 32'hFFFF_FFFF, 1'b0, 4'b0000);
    rd("s_r2", 32'h20, 32'hAA22_CC44, 1'b0);
    idle();
`endif

    repeat (2) @(posedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
